// File: rtl/cpu_clock_ctrl.sv
// Run/step/halt clock-enable generator for a slow single-cycle core.
// Define CPU_CLOCK_CTRL_TICK_COUNT_EN to add a 32-bit tick_count output.
module cpu_clock_ctrl #(
    parameter logic [27:0] MAXCOUNT = 28'd5000000,
    parameter logic [15:0] DEBOUNCE = 16'd50000
) (
    input  logic        inclk,
    input  logic        rst_n,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        halt_req,
    input  logic [1:0]  div_sel,
    output logic        clk_en,
    output logic        led_clk,
    output logic [1:0]  state,
`ifdef CPU_CLOCK_CTRL_TICK_COUNT_EN
    output logic [31:0] tick_count,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    localparam logic [27:0] LIMIT_DIV10  = MAXCOUNT / 28'd10;
    localparam logic [27:0] LIMIT_DIV100 = MAXCOUNT / 28'd100;

    state_t      fsm_state;
    logic [27:0] count;
    logic [27:0] limit;

    logic [1:0]  sync_ff;
    logic [1:0]  sync_fill;
    logic [15:0] deb_cnt;
    logic        deb_level;
    logic        deb_prev;
    logic        armed;
    logic        step_event;

    // NOTE: every path assigns limit via the default first, so no latch is inferred.
    always_comb begin
        limit = MAXCOUNT;
        case (div_sel)
            2'b01:   limit = LIMIT_DIV10;
            2'b10:   limit = LIMIT_DIV100;
            2'b11:   limit = '0;
            default: limit = MAXCOUNT;
        endcase
    end

    // Step events are suppressed until a confirmed-released button has been seen
    // after reset, so a button held through reset release cannot fire a step.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge inclk) begin
        if (!rst_n) begin
            sync_ff   <= 2'b00;
            sync_fill <= 2'b00;
            deb_cnt   <= '0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sync_ff   <= {sync_ff[0], step_btn};
            sync_fill <= {sync_fill[0], 1'b1};
            deb_prev  <= deb_level;
            if (sync_ff[1] != deb_level) begin
                if (deb_cnt >= DEBOUNCE - 16'd1) begin
                    deb_level <= sync_ff[1];
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 16'd1;
                end
            end else begin
                deb_cnt <= '0;
            end
            if (sync_fill[1] && !sync_ff[1] && !deb_level && (deb_cnt == '0)) begin
                armed <= 1'b1;
            end
        end
    end

    assign step_event = armed & deb_level & ~deb_prev;

    always_ff @(posedge inclk) begin
        if (!rst_n) begin
            fsm_state <= IDLE;
            count     <= '0;
            clk_en    <= 1'b0;
            led_clk   <= 1'b0;
            halted    <= 1'b0;
        end else begin
            clk_en <= 1'b0;
            case (fsm_state)
                IDLE: begin
                    count <= '0;
                    if (halt_req) begin
                        fsm_state <= HALT;
                        halted    <= 1'b1;
                    end else if (run_sw) begin
                        fsm_state <= RUN;
                    end else if (step_event) begin
                        fsm_state <= STEP;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        fsm_state <= HALT;
                        halted    <= 1'b1;
                        count     <= '0;
                    end else if (!run_sw) begin
                        fsm_state <= IDLE;
                        count     <= '0;
                    end else if (count > limit) begin
                        // Rate raised mid-count: restart the period silently.
                        count <= '0;
                    end else if (count == limit) begin
                        count   <= '0;
                        clk_en  <= 1'b1;
                        led_clk <= ~led_clk;
                    end else begin
                        count <= count + 28'd1;
                    end
                end
                STEP: begin
                    clk_en  <= 1'b1;
                    led_clk <= ~led_clk;
                    count   <= '0;
                    if (halt_req) begin
                        fsm_state <= HALT;
                        halted    <= 1'b1;
                    end else begin
                        fsm_state <= IDLE;
                    end
                end
                HALT: begin
                    count <= '0;
                    if (!halt_req && !run_sw) begin
                        fsm_state <= IDLE;
                        halted    <= 1'b0;
                    end
                end
                default: begin
                    fsm_state <= IDLE;
                    halted    <= 1'b0;
                    count     <= '0;
                end
            endcase
        end
    end

    assign state = fsm_state;

`ifdef CPU_CLOCK_CTRL_TICK_COUNT_EN
    logic [31:0] tick_cnt_q;

    // Counts pulses already issued, so it lags clk_en by one cycle and wraps freely.
    always_ff @(posedge inclk) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (clk_en) begin
            tick_cnt_q <= tick_cnt_q + 32'd1;
        end
    end

    assign tick_count = tick_cnt_q;
`endif

endmodule
